// File: rtl/dds_frame_if.sv
// dds_frame_if: host byte stream in, READY handshake and committed DDS parameter bus out.
interface dds_frame_if;
    logic [7:0]  RXD;
    logic        RXV;
    logic        READY;
    logic [15:0] F1H, F2H, DFWH;
    logic [31:0] F1L, F2L, DFWL;
    logic [13:0] PTW1, PTW2;
    logic [19:0] RAMPRATE;
    logic [2:0]  MODE;
    logic        TRAIANGLE, PLLEN, PLLRANGE;
    logic [4:0]  CLKMUILT;
    logic        CEN, BUSY, FRAME_OK, CSUM_ERR, MODE_ERR, TOUT_ERR;
    modport master (
        output RXD, RXV, READY,
        input  F1H, F2H, DFWH, F1L, F2L, DFWL, PTW1, PTW2, RAMPRATE, MODE,
               TRAIANGLE, PLLEN, PLLRANGE, CLKMUILT, CEN, BUSY, FRAME_OK,
               CSUM_ERR, MODE_ERR, TOUT_ERR
    );
    modport slave (
        input  RXD, RXV, READY,
        output F1H, F2H, DFWH, F1L, F2L, DFWL, PTW1, PTW2, RAMPRATE, MODE,
               TRAIANGLE, PLLEN, PLLRANGE, CLKMUILT, CEN, BUSY, FRAME_OK,
               CSUM_ERR, MODE_ERR, TOUT_ERR
    );
endinterface

// File: rtl/dds_frame_loader.sv
// dds_frame_loader: parses 0xA5-headed 29-byte host frames into DDS parameters and
// runs the CEN/READY handshake with the DDS programmer.
module dds_frame_loader #(
    parameter int GAP_MAX     = 50000,
    parameter int RDY_TIMEOUT = 1000000
) (
    input logic       CLK,
    input logic       RST,
    dds_frame_if.slave bus
);
    localparam int GW = $clog2(GAP_MAX + 1);
    localparam int TW = $clog2(RDY_TIMEOUT + 1);
    typedef enum logic [2:0] {HUNT, PAYLOAD, CSUM, COMMIT, WAIT_RDY} state_t;
    typedef struct packed {
        logic [5:0]  cfg;
        logic [4:0]  mul;
        logic [47:0] f1;
        logic [47:0] f2;
        logic [47:0] dfw;
        logic [13:0] ptw1;
        logic [13:0] ptw2;
        logic [19:0] ramp;
    } params_t;
    state_t        state_q, state_d;
    logic [4:0]    idx_q, idx_d;
    logic [215:0]  shadow_q, shadow_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [1:0]    rdy_q, rdy_d;
    params_t       par_q, par_d, par_new;
    logic          cen_q, cen_d;
    logic          frame_ok_q, frame_ok_d;
    logic          csum_err_q, csum_err_d;
    logic          mode_err_q, mode_err_d;
    logic          tout_q, tout_d;
    logic [7:0]    calc;
    logic          gap_out;
    // Shadow shifts bytes in at the bottom, so payload byte 0 (CFG) ends up in the top byte.
    assign par_new = '{
        cfg:  shadow_q[213:208],
        mul:  shadow_q[204:200],
        f1:   shadow_q[199:152],
        f2:   shadow_q[151:104],
        dfw:  shadow_q[103:56],
        ptw1: shadow_q[53:40],
        ptw2: shadow_q[37:24],
        ramp: shadow_q[19:0]
    };
    assign gap_out = gap_q == GW'(GAP_MAX - 1);
    assign rdy_d   = {rdy_q[0], bus.READY};
    always_comb begin
        calc = '0;
        for (int i = 0; i < 27; i++) calc ^= shadow_q[i*8 +: 8];
    end
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        shadow_d   = shadow_q;
        gap_d      = '0;
        tcnt_d     = '0;
        par_d      = par_q;
        cen_d      = cen_q;
        frame_ok_d = 1'b0;
        csum_err_d = 1'b0;
        mode_err_d = 1'b0;
        tout_d     = tout_q;
        case (state_q)
            HUNT: begin
                if (bus.RXV && bus.RXD == 8'hA5) begin
                    state_d = PAYLOAD;
                    idx_d   = '0;
                end
            end
            PAYLOAD: begin
                if (bus.RXV) begin
                    shadow_d = {shadow_q[207:0], bus.RXD};
                    idx_d    = idx_q + 5'd1;
                    state_d  = idx_q == 5'd26 ? CSUM : PAYLOAD;
                end else begin
                    gap_d   = gap_q + GW'(1);
                    state_d = gap_out ? HUNT : PAYLOAD;
                end
            end
            CSUM: begin
                if (bus.RXV) begin
                    csum_err_d = bus.RXD != calc;
                    mode_err_d = bus.RXD == calc && shadow_q[210:208] > 3'd4;
                    state_d    = bus.RXD == calc && shadow_q[210:208] <= 3'd4 ? COMMIT : HUNT;
                end else begin
                    gap_d   = gap_q + GW'(1);
                    state_d = gap_out ? HUNT : CSUM;
                end
            end
            COMMIT: begin
                par_d      = par_new;
                cen_d      = 1'b1;
                frame_ok_d = 1'b1;
                tout_d     = 1'b0;
                state_d    = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (rdy_q[1]) begin
                    cen_d   = 1'b0;
                    state_d = HUNT;
                end else if (tcnt_q == TW'(RDY_TIMEOUT - 1)) begin
                    cen_d   = 1'b0;
                    tout_d  = 1'b1;
                    state_d = HUNT;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            default: state_d = HUNT;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= HUNT;
            idx_q      <= '0;
            shadow_q   <= '0;
            gap_q      <= '0;
            tcnt_q     <= '0;
            rdy_q      <= '0;
            par_q      <= '0;
            cen_q      <= 1'b0;
            frame_ok_q <= 1'b0;
            csum_err_q <= 1'b0;
            mode_err_q <= 1'b0;
            tout_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            gap_q      <= gap_d;
            tcnt_q     <= tcnt_d;
            rdy_q      <= rdy_d;
            par_q      <= par_d;
            cen_q      <= cen_d;
            frame_ok_q <= frame_ok_d;
            csum_err_q <= csum_err_d;
            mode_err_q <= mode_err_d;
            tout_q     <= tout_d;
        end
    end
    // BUSY spans exactly the CEN window: both rise at commit and fall when the handshake ends.
    assign bus.MODE      = par_q.cfg[2:0];
    assign bus.TRAIANGLE = par_q.cfg[3];
    assign bus.PLLEN     = par_q.cfg[4];
    assign bus.PLLRANGE  = par_q.cfg[5];
    assign bus.CLKMUILT  = par_q.mul;
    assign bus.F1H       = par_q.f1[47:32];
    assign bus.F1L       = par_q.f1[31:0];
    assign bus.F2H       = par_q.f2[47:32];
    assign bus.F2L       = par_q.f2[31:0];
    assign bus.DFWH      = par_q.dfw[47:32];
    assign bus.DFWL      = par_q.dfw[31:0];
    assign bus.PTW1      = par_q.ptw1;
    assign bus.PTW2      = par_q.ptw2;
    assign bus.RAMPRATE  = par_q.ramp;
    assign bus.CEN       = cen_q;
    assign bus.BUSY      = cen_q;
    assign bus.FRAME_OK  = frame_ok_q;
    assign bus.CSUM_ERR  = csum_err_q;
    assign bus.MODE_ERR  = mode_err_q;
    assign bus.TOUT_ERR  = tout_q;
endmodule
